// File: rtl/sw_alloc_pkg.sv
// rtl/sw_alloc_pkg.sv - shared sizes, port names and lock entry type for the switch allocator
package sw_alloc_pkg;

  localparam int DEF_NUM_PORTS = 5;
  localparam int DEF_NUM_VCS   = 4;
  localparam int PORT_BITS     = $clog2(DEF_NUM_PORTS);
  localparam int VC_BITS       = $clog2(DEF_NUM_VCS);

  typedef enum logic [PORT_BITS-1:0] {
    PORT_N,
    PORT_E,
    PORT_S,
    PORT_W,
    PORT_L
  } port_e;

  // Wormhole ownership of one output: which input VC currently holds it.
  typedef struct packed {
    logic                 locked;
    logic [PORT_BITS-1:0] port;
    logic [VC_BITS-1:0]   vc;
  } lock_t;

endpackage

// File: rtl/sw_alloc_if.sv
// rtl/sw_alloc_if.sv - request/grant and crossbar-select bundle between VC buffers and the switch allocator
interface sw_alloc_if
  import sw_alloc_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int NUM_VCS   = DEF_NUM_VCS
);

  logic [NUM_PORTS*NUM_VCS-1:0]           sa_req;
  logic [NUM_PORTS*NUM_VCS*PORT_BITS-1:0] sa_route;
  logic [NUM_PORTS*NUM_VCS-1:0]           sa_tail;
  logic [NUM_PORTS-1:0]                   out_ready;
  logic [NUM_PORTS*NUM_VCS-1:0]           sa_gnt;
  logic [NUM_PORTS-1:0]                   xbar_valid;
  logic [NUM_PORTS*PORT_BITS-1:0]         xbar_sel;
  logic [NUM_PORTS*VC_BITS-1:0]           xbar_vc;

  modport master (
    output sa_req, sa_route, sa_tail, out_ready,
    input  sa_gnt, xbar_valid, xbar_sel, xbar_vc
  );

  modport slave (
    input  sa_req, sa_route, sa_tail, out_ready,
    output sa_gnt, xbar_valid, xbar_sel, xbar_vc
  );

endinterface

// File: rtl/sw_alloc_rr_arb.sv
// rtl/sw_alloc_rr_arb.sv - combinational round-robin arbiter; search starts at ptr and wraps
module sw_alloc_rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/sw_alloc.sv
// rtl/sw_alloc.sv - separable input-first iSLIP switch allocator with registered crossbar select
// Optional wormhole output locking: define SW_ALLOC_PKT_LOCK_EN.
module sw_alloc
  import sw_alloc_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int NUM_VCS   = DEF_NUM_VCS
) (
  input logic       clk,
  input logic       rst,
  sw_alloc_if.slave bus
);

  logic [PORT_BITS-1:0] route    [NUM_PORTS][NUM_VCS];
  logic [NUM_VCS-1:0]   elig     [NUM_PORTS];
  logic [NUM_VCS-1:0]   s1_req   [NUM_PORTS];
  logic [NUM_VCS-1:0]   s1_gnt   [NUM_PORTS];
  logic [VC_BITS-1:0]   s1_idx   [NUM_PORTS];
  logic                 s1_any   [NUM_PORTS];
  logic [PORT_BITS-1:0] s1_route [NUM_PORTS];
  logic [NUM_PORTS-1:0] s2_req   [NUM_PORTS];  // [output][input]
  logic [NUM_PORTS-1:0] s2_gnt   [NUM_PORTS];
  logic [PORT_BITS-1:0] s2_idx   [NUM_PORTS];
  logic                 s2_any   [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_won;
  logic [VC_BITS-1:0]   in_ptr   [NUM_PORTS];
  logic [PORT_BITS-1:0] out_ptr  [NUM_PORTS];
  logic [NUM_PORTS-1:0] xv_q;
  logic [PORT_BITS-1:0] xs_q     [NUM_PORTS];
  logic [VC_BITS-1:0]   xc_q     [NUM_PORTS];

`ifdef SW_ALLOC_PKT_LOCK_EN
  lock_t lock_q [NUM_PORTS];
`else
  logic unused_tail;
  assign unused_tail = ^bus.sa_tail;
`endif

  // Route decode never matches an index >= NUM_PORTS, so bad routes drop out here.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        route[p][v] = bus.sa_route[(p*NUM_VCS+v)*PORT_BITS +: PORT_BITS];
        elig[p][v]  = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (bus.sa_req[p*NUM_VCS+v] && route[p][v] == PORT_BITS'(o) && bus.out_ready[o]
`ifdef SW_ALLOC_PKT_LOCK_EN
              && !(lock_q[o].locked &&
                   (lock_q[o].port != PORT_BITS'(p) || lock_q[o].vc != VC_BITS'(v)))
`endif
             ) begin
            elig[p][v] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      s1_req[p] = elig[p];
`ifdef SW_ALLOC_PKT_LOCK_EN
      // Descending scan: if a port owns several outputs, the lowest one decides.
      for (int o = NUM_PORTS - 1; o >= 0; o--) begin
        if (lock_q[o].locked && lock_q[o].port == PORT_BITS'(p) && elig[p][lock_q[o].vc]) begin
          s1_req[p]                 = '0;
          s1_req[p][lock_q[o].vc]   = 1'b1;
        end
      end
`endif
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    sw_alloc_rr_arb #(.N(NUM_VCS), .IW(VC_BITS)) u_arb (
      .req (s1_req[p]),
      .ptr (in_ptr[p]),
      .gnt (s1_gnt[p]),
      .idx (s1_idx[p]),
      .any (s1_any[p])
    );
    assign s1_route[p] = route[p][s1_idx[p]];
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        s2_req[o][p] = s1_any[p] && (s1_route[p] == PORT_BITS'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    sw_alloc_rr_arb #(.N(NUM_PORTS), .IW(PORT_BITS)) u_arb (
      .req (s2_req[o]),
      .ptr (out_ptr[o]),
      .gnt (s2_gnt[o]),
      .idx (s2_idx[o]),
      .any (s2_any[o])
    );
    assign bus.xbar_sel[o*PORT_BITS +: PORT_BITS] = xs_q[o];
    assign bus.xbar_vc[o*VC_BITS +: VC_BITS]      = xc_q[o];
  end

  assign bus.xbar_valid = xv_q;

  always_comb begin
    in_won     = '0;
    bus.sa_gnt = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (s2_any[o]) in_won[s2_idx[o]] = 1'b1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        bus.sa_gnt[p*NUM_VCS+v] = s1_gnt[p][v] && in_won[p];
      end
    end
  end

  // Input pointers move only when the stage-1 choice survives stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      xv_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        in_ptr[i]  <= '0;
        out_ptr[i] <= '0;
        xs_q[i]    <= '0;
        xc_q[i]    <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (in_won[p]) begin
          in_ptr[p] <= (s1_idx[p] == VC_BITS'(NUM_VCS - 1)) ? '0 : s1_idx[p] + 1'b1;
        end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        xv_q[o] <= s2_any[o];
        if (s2_any[o]) begin
          out_ptr[o] <= (s2_idx[o] == PORT_BITS'(NUM_PORTS - 1)) ? '0 : s2_idx[o] + 1'b1;
          xs_q[o]    <= s2_idx[o];
          xc_q[o]    <= s1_idx[s2_idx[o]];
        end
      end
    end
  end

`ifdef SW_ALLOC_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) lock_q[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (s2_any[o]) begin
          if (bus.sa_tail[int'(s2_idx[o])*NUM_VCS + int'(s1_idx[s2_idx[o]])]) begin
            lock_q[o] <= '0;
          end else begin
            lock_q[o] <= '{locked: 1'b1, port: s2_idx[o], vc: s1_idx[s2_idx[o]]};
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sw_alloc.sv
// tb/tb_sw_alloc.sv - directed and randomized checks of sw_alloc against a behavioural allocator model
module tb_sw_alloc;
  import sw_alloc_pkg::*;

  localparam int NP = DEF_NUM_PORTS;
  localparam int NV = DEF_NUM_VCS;
  localparam int NB = NP * NV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sw_alloc_if #(.NUM_PORTS(NP), .NUM_VCS(NV)) bus ();
  sw_alloc #(.NUM_PORTS(NP), .NUM_VCS(NV)) dut (.clk(clk), .rst(rst), .bus(bus));

  bit rq  [NP][NV];
  bit tl  [NP][NV];
  int rt  [NP][NV];
  bit rdy [NP];

  int in_ptr_m  [NP];
  int out_ptr_m [NP];
  int w1 [NP];
  int w2 [NP];
  logic [NB-1:0] e_gnt;
  logic [NP-1:0] e_xv;
  int e_xs [NP];
  int e_xc [NP];
`ifdef SW_ALLOC_PKT_LOCK_EN
  bit lk_on [NP];
  int lk_p  [NP];
  int lk_v  [NP];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int sel_of(int o);
    return int'(bus.xbar_sel[o*PORT_BITS +: PORT_BITS]);
  endfunction

  function automatic int vc_of(int o);
    return int'(bus.xbar_vc[o*VC_BITS +: VC_BITS]);
  endfunction

  function automatic bit eligible(int p, int v);
    int r;
    r = rt[p][v];
    if (!rq[p][v] || r >= NP || !rdy[r]) return 1'b0;
`ifdef SW_ALLOC_PKT_LOCK_EN
    if (lk_on[r] && (lk_p[r] != p || lk_v[r] != v)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic clear_inputs();
    for (int p = 0; p < NP; p++) begin
      rdy[p] = 1'b1;
      for (int v = 0; v < NV; v++) begin
        rq[p][v] = 1'b0;
        tl[p][v] = 1'b0;
        rt[p][v] = 0;
      end
    end
  endtask

  // Drive the stimulus arrays and predict this cycle's grants.
  task automatic drive_eval();
    int forced;
    int p;
    for (int i = 0; i < NP; i++) begin
      for (int j = 0; j < NV; j++) begin
        bus.sa_req[i*NV+j]  = rq[i][j];
        bus.sa_tail[i*NV+j] = tl[i][j];
        bus.sa_route[(i*NV+j)*PORT_BITS +: PORT_BITS] = PORT_BITS'(rt[i][j]);
      end
      bus.out_ready[i] = rdy[i];
    end
    #1;
    for (int i = 0; i < NP; i++) begin
      w1[i]  = -1;
      forced = -1;
`ifdef SW_ALLOC_PKT_LOCK_EN
      for (int o = 0; o < NP; o++)
        if (forced < 0 && lk_on[o] && lk_p[o] == i && eligible(i, lk_v[o])) forced = lk_v[o];
`endif
      if (forced >= 0) w1[i] = forced;
      else
        for (int k = 0; k < NV; k++)
          if (w1[i] < 0 && eligible(i, (in_ptr_m[i] + k) % NV)) w1[i] = (in_ptr_m[i] + k) % NV;
    end
    for (int o = 0; o < NP; o++) begin
      w2[o] = -1;
      for (int k = 0; k < NP; k++) begin
        p = (out_ptr_m[o] + k) % NP;
        if (w2[o] < 0 && w1[p] >= 0 && rt[p][w1[p]] == o) w2[o] = p;
      end
    end
    e_gnt = '0;
    for (int o = 0; o < NP; o++)
      if (w2[o] >= 0) e_gnt[w2[o]*NV + w1[w2[o]]] = 1'b1;
  endtask

  task automatic step();
    int p;
    int v;
    @(posedge clk);
    e_xv = '0;
    for (int o = 0; o < NP; o++) begin
      if (rst) begin
        in_ptr_m[o]  = 0;
        out_ptr_m[o] = 0;
        e_xs[o]      = 0;
        e_xc[o]      = 0;
`ifdef SW_ALLOC_PKT_LOCK_EN
        lk_on[o] = 1'b0;
`endif
      end else if (w2[o] >= 0) begin
        p = w2[o];
        v = w1[p];
        e_xv[o]      = 1'b1;
        e_xs[o]      = p;
        e_xc[o]      = v;
        out_ptr_m[o] = (p + 1) % NP;
        in_ptr_m[p]  = (v + 1) % NV;
`ifdef SW_ALLOC_PKT_LOCK_EN
        lk_on[o] = !tl[p][v];
        lk_p[o]  = p;
        lk_v[o]  = v;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    drive_eval();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    rq[0][0] = 1'b1;
    rt[0][0] = 2;
    drive_eval();
    step();
    rst = 1'b0;
    clear_inputs();
    drive_eval();
    n_cmp++; if (bus.xbar_valid !== '0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.xbar_valid); end
    n_cmp++; if (bus.xbar_sel !== '0) begin n_bad++; $display("FAIL reset_sel: got %h want 0", bus.xbar_sel); end
    n_cmp++; if (bus.xbar_vc !== '0) begin n_bad++; $display("FAIL reset_vc: got %h want 0", bus.xbar_vc); end
    n_cmp++; if (bus.sa_gnt !== '0) begin n_bad++; $display("FAIL reset_gnt: got %h want 0", bus.sa_gnt); end
    step();
  endtask

  task automatic test_single();
    do_reset();
    rq[0][0] = 1'b1;
    rt[0][0] = 2;
    for (int c = 0; c < 4; c++) begin
      drive_eval();
      n_cmp++; if (bus.sa_gnt !== NB'(1)) begin n_bad++; $display("FAIL single_gnt c%0d: got %h want %h", c, bus.sa_gnt, NB'(1)); end
      n_cmp++; if (bus.xbar_valid !== ((c == 0) ? 5'b00000 : 5'b00100)) begin n_bad++; $display("FAIL single_valid c%0d: got %b", c, bus.xbar_valid); end
      if (c > 0) begin
        n_cmp++; if (sel_of(2) !== 0 || vc_of(2) !== 0) begin n_bad++; $display("FAIL single_sel c%0d: got sel %0d vc %0d want 0 0", c, sel_of(2), vc_of(2)); end
      end
      step();
    end
  endtask

  task automatic test_alternate();
    logic [NB-1:0] want;
    int wp;
    int prev;
    do_reset();
    rq[1][0] = 1'b1; rt[1][0] = 4;
    rq[3][0] = 1'b1; rt[3][0] = 4;
    prev = -1;
    for (int c = 0; c < 5; c++) begin
      drive_eval();
      wp = (c % 2 == 0) ? 1 : 3;
      want = '0;
      want[wp*NV] = 1'b1;
      n_cmp++; if (bus.sa_gnt !== want) begin n_bad++; $display("FAIL alt_gnt c%0d: got %h want %h", c, bus.sa_gnt, want); end
      if (prev >= 0) begin
        n_cmp++; if (bus.xbar_valid !== 5'b10000 || sel_of(4) !== prev) begin n_bad++; $display("FAIL alt_sel c%0d: got v %b sel %0d want 10000 %0d", c, bus.xbar_valid, sel_of(4), prev); end
      end
      prev = wp;
      step();
    end
  endtask

  task automatic test_vc_wrap();
    logic [NB-1:0] want;
    int pv;
    do_reset();
    for (int v = 0; v < NV; v++) begin
      rq[2][v] = 1'b1;
      rt[2][v] = (v < 2) ? v : v + 1;
    end
    pv = -1;
    for (int c = 0; c < 6; c++) begin
      drive_eval();
      want = '0;
      want[2*NV + c % NV] = 1'b1;
      n_cmp++; if (bus.sa_gnt !== want) begin n_bad++; $display("FAIL wrap_gnt c%0d: got %h want %h", c, bus.sa_gnt, want); end
      if (pv >= 0) begin
        n_cmp++; if (bus.xbar_valid !== NP'(1 << rt[2][pv]) || vc_of(rt[2][pv]) !== pv || sel_of(rt[2][pv]) !== 2) begin
          n_bad++; $display("FAIL wrap_xbar c%0d: got v %b vc %0d want vc %0d", c, bus.xbar_valid, vc_of(rt[2][pv]), pv);
        end
      end
      pv = c % NV;
      step();
    end
  endtask

  task automatic test_out_ready();
    do_reset();
    rdy[1] = 1'b0;
    rq[0][1] = 1'b1;
    rt[0][1] = 1;
    for (int c = 0; c < 3; c++) begin
      drive_eval();
      n_cmp++; if (bus.sa_gnt !== '0 || bus.xbar_valid !== '0) begin n_bad++; $display("FAIL rdy_block c%0d: got gnt %h v %b want 0 0", c, bus.sa_gnt, bus.xbar_valid); end
      step();
    end
    rdy[1] = 1'b1;
    drive_eval();
    n_cmp++; if (bus.sa_gnt !== NB'(2)) begin n_bad++; $display("FAIL rdy_open_gnt: got %h want %h", bus.sa_gnt, NB'(2)); end
    step();
    n_cmp++; if (bus.xbar_valid !== 5'b00010 || sel_of(1) !== 0 || vc_of(1) !== 1) begin
      n_bad++; $display("FAIL rdy_open_xbar: got v %b sel %0d vc %0d want 00010 0 1", bus.xbar_valid, sel_of(1), vc_of(1));
    end
  endtask

  task automatic test_bad_route();
    logic [NB-1:0] want;
    do_reset();
    rq[3][0] = 1'b1; rt[3][0] = 0;
    rq[3][2] = 1'b1; rt[3][2] = 7;
    rq[3][3] = 1'b1; rt[3][3] = 1;
    for (int c = 0; c < 6; c++) begin
      drive_eval();
      want = '0;
      want[3*NV + ((c % 2 == 0) ? 0 : 3)] = 1'b1;
      n_cmp++; if (bus.sa_gnt !== want) begin n_bad++; $display("FAIL badroute_gnt c%0d: got %h want %h", c, bus.sa_gnt, want); end
      step();
    end
  endtask

  task automatic test_packet();
    logic [NB-1:0] want;
    int flits;
    int wp;
    do_reset();
    flits = 0;
    for (int c = 0; c < 7; c++) begin
      rq[0][0] = (flits < 3); rt[0][0] = 3; tl[0][0] = (flits == 2);
      rq[1][0] = 1'b1;        rt[1][0] = 3; tl[1][0] = 1'b1;
      drive_eval();
`ifdef SW_ALLOC_PKT_LOCK_EN
      wp = (c < 3) ? 0 : 1;
`else
      wp = (c < 5) ? (c % 2) : 1;
`endif
      want = '0;
      want[wp*NV] = 1'b1;
      n_cmp++; if (bus.sa_gnt !== want) begin n_bad++; $display("FAIL packet_gnt c%0d: got %h want %h", c, bus.sa_gnt, want); end
      n_cmp++; if (bus.sa_gnt !== e_gnt) begin n_bad++; $display("FAIL packet_model c%0d: got %h want %h", c, bus.sa_gnt, e_gnt); end
      if (wp == 0) flits++;
      step();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < NP; p++) begin
        rdy[p] = ($urandom_range(0, 4) != 0);
        for (int v = 0; v < NV; v++) begin
          rq[p][v] = ($urandom_range(0, 2) != 0);
          tl[p][v] = ($urandom_range(0, 3) == 0);
          rt[p][v] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        end
      end
      drive_eval();
      n_cmp++; if (bus.sa_gnt !== e_gnt) begin n_bad++; $display("FAIL rand_gnt c%0d: got %h want %h", c, bus.sa_gnt, e_gnt); end
      n_cmp++; if (bus.xbar_valid !== e_xv) begin n_bad++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.xbar_valid, e_xv); end
      for (int o = 0; o < NP; o++) begin
        if (e_xv[o]) begin
          n_cmp++; if (sel_of(o) !== e_xs[o] || vc_of(o) !== e_xc[o]) begin
            n_bad++; $display("FAIL rand_xbar c%0d o%0d: got sel %0d vc %0d want %0d %0d", c, o, sel_of(o), vc_of(o), e_xs[o], e_xc[o]);
          end
        end
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    drive_eval();
    step();
    step();
    test_reset();
    test_single();
    test_alternate();
    test_vc_wrap();
    test_out_ready();
    test_bad_route();
    test_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
